exec_logic_pipe: RTL and testbench

//  Parametrised, pipelined logic unit for the exec stage; successor to the single-cycle 4-op logic unit.

---
 rtl/exec_logic_pipe.sv | 171 +++++++++++++++++
 tb/tb_exec_logic_pipe.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_logic_pipe.sv
// -----------------------------------------------------------------------------
// exec_logic_pipe
//
// Two-stage pipelined bitwise logic unit for the exec stage. It accepts one
// operation per cycle over a valid/ready handshake and returns the result two
// cycles later. The tag travels with the operation so writeback can route it,
// and a zero flag is reported alongside the result.
//
//   Stage S1 : captures select/operands/tag when an operation is accepted.
//   Stage S2 : evaluates the op from the S1 registers and loads the output regs.
//
// Op codes (select_i):
//   000 AND   001 OR    010 NOT opr0   011 XOR
//   100 NAND  101 NOR   110 XNOR       111 ANDN (opr0 & ~opr1)
//
// Optional build macro: EXEC_LOGIC_POPCNT_EN
//   When defined, op 111 becomes the population count of opr0, zero-extended
//   to W_OPR bits, and ANDN is unavailable. Latency is unchanged.
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_i        in   asynchronous active-high reset
//   flush_i      in   synchronous clear of all in-flight operations
//   in_valid_i   in   operation offered
//   in_ready_o   out  unit accepts this cycle
//   select_i     in   op code [2:0]
//   opr0_i       in   operand 0 [W_OPR-1:0]
//   opr1_i       in   operand 1 [W_OPR-1:0]
//   tag_i        in   tag [W_TAG-1:0]
//   out_valid_o  out  result valid
//   out_ready_i  in   consumer takes result
//   result_o     out  result [W_OPR-1:0]
//   tag_o        out  tag of result [W_TAG-1:0]
//   zero_o       out  result_o == 0
// -----------------------------------------------------------------------------
module exec_logic_pipe #(
    parameter int W_OPR = 32,
    parameter int W_TAG = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       select_i,
    input  logic [W_OPR-1:0] opr0_i,
    input  logic [W_OPR-1:0] opr1_i,
    input  logic [W_TAG-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W_OPR-1:0] result_o,
    output logic [W_TAG-1:0] tag_o,
    output logic             zero_o
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;
    localparam logic [2:0] OP_OP7  = 3'b111;

    // Stage S1 registers
    logic             s1_valid_reg;
    logic [2:0]       s1_sel_reg;
    logic [W_OPR-1:0] s1_opr0_reg;
    logic [W_OPR-1:0] s1_opr1_reg;
    logic [W_TAG-1:0] s1_tag_reg;

    // Output (S2) registers
    logic             out_valid_reg;
    logic [W_OPR-1:0] result_reg;
    logic [W_TAG-1:0] tag_reg;
    logic             zero_reg;

    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic [W_OPR-1:0] op_result_next;

    // The output register can take a new value when it is empty or being
    // drained this cycle; S1 moves forward only into such a free slot.
    assign s2_adv = !out_valid_reg || out_ready_i;
    assign s1_adv = s1_valid_reg && s2_adv;

    // S1 frees up either because it is empty or because it advances this cycle,
    // which lets a new op enter behind a departing one with no bubble. A flush
    // refuses same-cycle input so the flushed edge leaves the pipe empty.
    assign in_ready_o = !flush_i && (!s1_valid_reg || s2_adv);
    assign accept     = in_valid_i && in_ready_o;

`ifdef EXEC_LOGIC_POPCNT_EN
    logic [W_OPR-1:0] pop_count;

    always_comb begin
        pop_count = '0;
        for (int i = 0; i < W_OPR; i++) begin
            pop_count = pop_count + W_OPR'(s1_opr0_reg[i]);
        end
    end
`endif

    // S2 combinational evaluation from the S1 registers
    always_comb begin
        op_result_next = '0;
        case (s1_sel_reg)
            OP_AND:  op_result_next = s1_opr0_reg & s1_opr1_reg;
            OP_OR:   op_result_next = s1_opr0_reg | s1_opr1_reg;
            OP_NOT:  op_result_next = ~s1_opr0_reg;
            OP_XOR:  op_result_next = s1_opr0_reg ^ s1_opr1_reg;
            OP_NAND: op_result_next = ~(s1_opr0_reg & s1_opr1_reg);
            OP_NOR:  op_result_next = ~(s1_opr0_reg | s1_opr1_reg);
            OP_XNOR: op_result_next = ~(s1_opr0_reg ^ s1_opr1_reg);
`ifdef EXEC_LOGIC_POPCNT_EN
            OP_OP7:  op_result_next = pop_count;
`else
            OP_OP7:  op_result_next = s1_opr0_reg & ~s1_opr1_reg;
`endif
            default: op_result_next = '0;
        endcase
    end

    // Stage S1
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_reg <= 1'b0;
            s1_sel_reg   <= '0;
            s1_opr0_reg  <= '0;
            s1_opr1_reg  <= '0;
            s1_tag_reg   <= '0;
        end else if (flush_i) begin
            s1_valid_reg <= 1'b0;
        end else if (accept) begin
            s1_valid_reg <= 1'b1;
            s1_sel_reg   <= select_i;
            s1_opr0_reg  <= opr0_i;
            s1_opr1_reg  <= opr1_i;
            s1_tag_reg   <= tag_i;
        end else if (s1_adv) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // Stage S2 / output registers. Data only loads on an advance, so the
    // outputs stay frozen while stalled and keep their last values when empty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            tag_reg       <= '0;
            zero_reg      <= 1'b1;
        end else if (flush_i) begin
            out_valid_reg <= 1'b0;
        end else if (s1_adv) begin
            out_valid_reg <= 1'b1;
            result_reg    <= op_result_next;
            tag_reg       <= s1_tag_reg;
            zero_reg      <= (op_result_next == '0);
        end else if (out_ready_i) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_reg;
    assign result_o    = result_reg;
    assign tag_o       = tag_reg;
    assign zero_o      = zero_reg;

endmodule

// File: tb/tb_exec_logic_pipe.sv
// -----------------------------------------------------------------------------
// tb_exec_logic_pipe
//
// Directed self-checking bench for exec_logic_pipe (W_OPR=32, W_TAG=5).
// One task per scenario; inputs are driven 1 ns after the rising edge and
// outputs are sampled at the same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_exec_logic_pipe;

    logic        clk_i;
    logic        rst_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [2:0]  select_i;
    logic [31:0] opr0_i;
    logic [31:0] opr1_i;
    logic [4:0]  tag_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic [4:0]  tag_o;
    logic        zero_o;

    int checks;
    int failures;

    exec_logic_pipe #(.W_OPR(32), .W_TAG(5)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .select_i    (select_i),
        .opr0_i      (opr0_i),
        .opr1_i      (opr1_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .tag_o       (tag_o),
        .zero_o      (zero_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] t);
        in_valid_i = v;
        select_i   = sel;
        opr0_i     = a;
        opr1_i     = b;
        tag_i      = t;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset;
        rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1;
        drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
        step; step;
        rst_i = 1'b0;
        step;
        checks++;
        if (out_valid_o !== 1'b0 || zero_o !== 1'b1 || result_o !== 32'h0 || tag_o !== 5'd0) begin
            failures++;
            $display("FAIL reset_state: valid=%b zero=%b result=%h tag=%0d required valid=0 zero=1 result=0 tag=0",
                     out_valid_o, zero_o, result_o, tag_o);
        end
        checks++;
        if (in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: in_ready=%b required 1", in_ready_o);
        end
        $display("reset: valid=%b zero=%b in_ready=%b", out_valid_o, zero_o, in_ready_o);

        // Put two ops in flight, then reset asynchronously mid-cycle.
        drive(1'b1, 3'd1, 32'h1234_0000, 32'h0000_5678, 5'd3); step;
        drive(1'b1, 3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 5'd4); step;
        drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
        checks++;
        if (out_valid_o !== 1'b1 || result_o !== 32'h1234_5678) begin
            failures++;
            $display("FAIL pre_reset_op: valid=%b result=%h required valid=1 result=12345678",
                     out_valid_o, result_o);
        end
        #3 rst_i = 1'b1;
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || zero_o !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: valid=%b zero=%b required valid=0 zero=1", out_valid_o, zero_o);
        end
        $display("async reset: valid=%b zero=%b", out_valid_o, zero_o);
        step;
        rst_i = 1'b0;
        #1;
        checks++;
        if (in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready_o);
        end
        for (int i = 0; i < 3; i++) begin
            step;
            checks++;
            if (out_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL reset_drop_%0d: valid=%b required 0", i, out_valid_o);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_ops;
        logic [31:0] expv [8];
        expv[0] = 32'hF000_000F; expv[1] = 32'hFFF0_0FFF;
        expv[2] = 32'h0F0F_FF00; expv[3] = 32'h0FF0_0FF0;
        expv[4] = 32'h0FFF_FFF0; expv[5] = 32'h000F_F000;
        expv[6] = 32'hF00F_F00F;
`ifdef EXEC_LOGIC_POPCNT_EN
        expv[7] = 32'h0000_0010;
`else
        expv[7] = 32'h00F0_00F0;
`endif
        out_ready_i = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k < 8) drive(1'b1, 3'(k), 32'hF0F0_00FF, 32'hFF00_0F0F, 5'(k + 16));
            else       drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
            if (k < 8) begin
                checks++;
                if (in_ready_o !== 1'b1) begin
                    failures++;
                    $display("FAIL ops_ready_%0d: in_ready=%b required 1", k, in_ready_o);
                end
            end
            step;
            if (k >= 1) begin
                checks++;
                if (out_valid_o !== 1'b1 || result_o !== expv[k-1] || tag_o !== 5'(k + 15)) begin
                    failures++;
                    $display("FAIL op_%0d: valid=%b result=%h tag=%0d required valid=1 result=%h tag=%0d",
                             k - 1, out_valid_o, result_o, tag_o, expv[k-1], k + 15);
                end
                $display("op %0d: result=%h tag=%0d", k - 1, result_o, tag_o);
            end
        end
        step;
        checks++;
        if (out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL ops_drain: valid=%b required 0", out_valid_o);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_backpressure;
        logic [31:0] expv [4];
        int sent, rcv;
        logic acc, took;
        expv[0] = 32'h0000_0101; expv[1] = 32'h0000_0102;
        expv[2] = 32'h0000_0104; expv[3] = 32'h0000_0108;
        sent = 0; rcv = 0;
        for (int cyc = 0; cyc < 30 && rcv < 4; cyc++) begin
            out_ready_i = (cyc >= 6);
            if (sent < 4) drive(1'b1, 3'd1, 32'h1 << sent, 32'h100, 5'(10 + sent));
            else          drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
            #1;
            acc  = in_valid_i && in_ready_o;
            took = out_valid_o && out_ready_i;
            if (cyc == 5) begin
                checks++;
                if (sent !== 2 || in_ready_o !== 1'b0 || out_valid_o !== 1'b1 ||
                    result_o !== expv[0] || tag_o !== 5'd10) begin
                    failures++;
                    $display("FAIL bp_stall: sent=%0d in_ready=%b valid=%b result=%h tag=%0d required sent=2 in_ready=0 valid=1 result=%h tag=10",
                             sent, in_ready_o, out_valid_o, result_o, tag_o, expv[0]);
                end
                $display("stall: accepted=%0d in_ready=%b result=%h", sent, in_ready_o, result_o);
            end
            if (took) begin
                checks++;
                if (rcv > 3 || result_o !== expv[rcv] || tag_o !== 5'(10 + rcv)) begin
                    failures++;
                    $display("FAIL bp_out_%0d: result=%h tag=%0d required result=%h tag=%0d",
                             rcv, result_o, tag_o, expv[rcv & 3], 10 + rcv);
                end
                $display("bp out %0d: result=%h tag=%0d", rcv, result_o, tag_o);
                rcv++;
            end
            @(posedge clk_i);
            #1;
            if (acc) sent++;
        end
        checks++;
        if (rcv !== 4 || sent !== 4) begin
            failures++;
            $display("FAIL bp_count: received=%0d sent=%0d required 4 and 4", rcv, sent);
        end
        drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
        step;
        checks++;
        if (out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL bp_no_dup: valid=%b required 0", out_valid_o);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_flush;
        out_ready_i = 1'b1;
        drive(1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0000_00AA, 5'd1); step;
        drive(1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0000_00BB, 5'd2); step;
        drive(1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0000_00CC, 5'd3);
        flush_i = 1'b1;
        #1;
        checks++;
        if (in_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready: in_ready=%b required 0", in_ready_o);
        end
        step;
        flush_i = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
        checks++;
        if (out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear: valid=%b required 0", out_valid_o);
        end
        step;
        checks++;
        if (out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_accept: valid=%b tag=%0d required valid=0", out_valid_o, tag_o);
        end
        drive(1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0000_00DD, 5'd25); step;
        drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0); step;
        checks++;
        if (out_valid_o !== 1'b1 || result_o !== 32'h0000_00DD || tag_o !== 5'd25) begin
            failures++;
            $display("FAIL flush_next: valid=%b result=%h tag=%0d required valid=1 result=000000dd tag=25",
                     out_valid_o, result_o, tag_o);
        end
        $display("flush: next result=%h tag=%0d", result_o, tag_o);
        step;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_zero_flag;
        out_ready_i = 1'b1;
        drive(1'b1, 3'd0, 32'h0000_FFFF, 32'hFFFF_0000, 5'd7); step;
        drive(1'b1, 3'd3, 32'h0000_0001, 32'h0000_0000, 5'd8); step;
        drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
        checks++;
        if (out_valid_o !== 1'b1 || result_o !== 32'h0 || zero_o !== 1'b1) begin
            failures++;
            $display("FAIL zero_set: valid=%b result=%h zero=%b required valid=1 result=0 zero=1",
                     out_valid_o, result_o, zero_o);
        end
        $display("zero and: result=%h zero=%b", result_o, zero_o);
        step;
        checks++;
        if (out_valid_o !== 1'b1 || result_o !== 32'h1 || zero_o !== 1'b0) begin
            failures++;
            $display("FAIL zero_clear: valid=%b result=%h zero=%b required valid=1 result=1 zero=0",
                     out_valid_o, result_o, zero_o);
        end
        $display("zero xor: result=%h zero=%b", result_o, zero_o);
        step;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_op7;
        logic [31:0] expv;
`ifdef EXEC_LOGIC_POPCNT_EN
        expv = 32'h0000_0003;
`else
        expv = 32'h8000_0002;
`endif
        out_ready_i = 1'b1;
        drive(1'b1, 3'd7, 32'h8000_0003, 32'h0000_0001, 5'd30); step;
        drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0); step;
        checks++;
        if (out_valid_o !== 1'b1 || result_o !== expv || tag_o !== 5'd30 || zero_o !== 1'b0) begin
            failures++;
            $display("FAIL op7: valid=%b result=%h tag=%0d zero=%b required valid=1 result=%h tag=30 zero=0",
                     out_valid_o, result_o, tag_o, zero_o, expv);
        end
        $display("op7: result=%h tag=%0d", result_o, tag_o);
        step;
    endtask

    // -------------------------------------------------------------------------
    initial begin
        checks   = 0;
        failures = 0;
        test_reset;
        test_ops;
        test_backpressure;
        test_flush;
        test_zero_flag;
        test_op7;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
